// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle RV32I control FSM over one shared memory port with
//               a req/ready handshake, stall watchdog and sticky trap.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
   parameter int unsigned USE_MEM_READY = 1,
   parameter int unsigned TIMEOUT       = 15,
   parameter int unsigned TO_W          = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       ALUR31,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic       trap,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BRANCH   = 4'd10,
      S_JALR     = 4'd11,
      S_JALRPC   = 4'd12,
      S_UPPER    = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [TO_W-1:0] wd_q, wd_d;
   logic            w_ready;
   logic            w_mem_state;
   logic            w_stall;
   logic            w_timeout;
   logic            w_take;
   logic            w_unused;

   // funct7b5 is consumed by the ALU decoder, not by this FSM.
   assign w_unused = funct7b5;

   generate
      if (USE_MEM_READY != 0) begin : g_ready_port
         assign w_ready = mem_ready;
      end else begin : g_ready_const
         logic w_unused_ready;
         assign w_unused_ready = mem_ready;
         assign w_ready        = 1'b1;
      end
   endgenerate

   assign w_mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                        (state_q == S_MEMWRITE);
   assign w_stall     = w_mem_state & ~w_ready;
   assign w_timeout   = w_stall & (wd_q == c_to_last);
   assign wd_d        = w_stall ? wd_q + TO_W'(1) : '0;

   always_comb begin
      w_take = 1'b0;
      case (funct3)
         3'b000:          w_take = Zero;
         3'b001:          w_take = ~Zero;
         3'b100, 3'b110:  w_take = ALUR31;
         3'b101, 3'b111:  w_take = ~ALUR31;
         default:         w_take = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            if (w_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target is computed here so BRANCH can reuse ALUOut.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            casez (op)
               7'b0000011, 7'b0100011: state_d = S_MEMADR;
               7'b0110011:             state_d = S_EXECR;
               7'b0010011:             state_d = S_EXECI;
               7'b1100011:             state_d = S_BRANCH;
               7'b1101111:             state_d = S_JAL;
               7'b1100111:             state_d = S_JALR;
               7'b0?10111:             state_d = S_UPPER;
               default:                state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
            if (w_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req  = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (w_ready) state_d = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
            state_d = S_ALUWB;
         end
         S_BRANCH: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            PCWrite = w_take;
            state_d = S_FETCH;
         end
         S_JALR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = S_JALRPC;
         end
         S_JALRPC: begin
            PCWrite = 1'b1;
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            state_d = S_ALUWB;
         end
         S_UPPER: begin
            ALUSrcA = op[5] ? 2'b11 : 2'b01;
            ALUSrcB = 2'b01;
            state_d = S_ALUWB;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      // A stalled access that exhausts the watchdog aborts with no strobes.
      if (w_timeout) begin
         state_d  = S_TRAP;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         MemWrite = 1'b0;
      end
      if (reset) begin
         mem_req  = 1'b0;
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

   always_comb begin
      ImmSrc = 3'b000;
      casez (op)
         7'b0100011: ImmSrc = 3'b001;
         7'b1100011: ImmSrc = 3'b010;
         7'b1101111: ImmSrc = 3'b011;
         7'b0?10111: ImmSrc = 3'b100;
         default:    ImmSrc = 3'b000;
      endcase
   end

   assign trap      = (state_q == S_TRAP);
   assign state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Randomized scoreboard bench for multicycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       ALUR31;
   logic       mem_ready;
   logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, trap;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
   logic [2:0] ImmSrc;
   logic [3:0] state_dbg;

   multicycle_controller #(
      .USE_MEM_READY (1),
      .TIMEOUT       (TIMEOUT),
      .TO_W          (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .funct3    (funct3),
      .funct7b5  (funct7b5),
      .Zero      (Zero),
      .ALUR31    (ALUR31),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .PCWrite   (PCWrite),
      .AdrSrc    (AdrSrc),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .ResultSrc (ResultSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .ImmSrc    (ImmSrc),
      .trap      (trap),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         trap;
      int         cyc;
      int         rw;
      int         pcw;
      int         memw;
      int         req;
      int         adr;
      logic [5:0] dsig;
      logic [5:0] xsig;
      logic [2:0] imm;
      logic [1:0] rsrc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Instruction classes: 0 load,1 store,2 R,3 I,4 branch,5 jal,6 jalr,7 lui,8 auipc,9 illegal
   function automatic int cls(input logic [6:0] o);
      case (o)
         7'b0000011: return 0;
         7'b0100011: return 1;
         7'b0110011: return 2;
         7'b0010011: return 3;
         7'b1100011: return 4;
         7'b1101111: return 5;
         7'b1100111: return 6;
         7'b0110111: return 7;
         7'b0010111: return 8;
         default:    return 9;
      endcase
   endfunction

   function automatic exp_t model(input logic [6:0] o, input logic [2:0] f, input bit z,
                                  input bit r, input int sf, input int sm);
      int         lat [9]  = '{5, 4, 4, 4, 3, 4, 5, 4, 4};
      logic [5:0] xs  [9]  = '{6'b10_01_00, 6'b10_01_00, 6'b10_00_10, 6'b10_01_10,
                               6'b10_00_01, 6'b01_10_00, 6'b10_01_00, 6'b11_01_00,
                               6'b01_01_00};
      logic [2:0] im  [9]  = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd2, 3'd3, 3'd0, 3'd4, 3'd4};
      exp_t e;
      int   c    = cls(o);
      bit   mem  = (c <= 1);
      bit   take;
      e = '{trap: 1'b0, cyc: 0, rw: 0, pcw: 0, memw: 0, req: 0, adr: 0,
            dsig: 6'd0, xsig: 6'd0, imm: 3'd0, rsrc: 2'd0};
      case (f)
         3'd0:       take = z;
         3'd1:       take = !z;
         3'd4, 3'd6: take = r;
         3'd5, 3'd7: take = !r;
         default:    take = 1'b0;
      endcase
      if (sf >= TIMEOUT) begin
         e.trap = 1'b1; e.cyc = TIMEOUT;
      end else if (c == 9) begin
         e.trap = 1'b1; e.cyc = sf + 2;
      end else if (mem && sm >= TIMEOUT) begin
         e.trap = 1'b1; e.cyc = sf + 3 + TIMEOUT;
      end else begin
         e.cyc  = lat[c] + sf + (mem ? sm : 0);
         e.rw   = (c == 1 || c == 4) ? 0 : 1;
         e.pcw  = 1 + ((c == 5 || c == 6) ? 1 : 0) + ((c == 4 && take) ? 1 : 0);
         e.memw = (c == 1) ? 1 : 0;
         e.req  = sf + 1 + (mem ? sm + 1 : 0);
         e.adr  = mem ? sm + 1 : 0;
         e.dsig = 6'b01_01_00;
         e.xsig = xs[c];
         e.imm  = im[c];
         e.rsrc = (c == 0) ? 2'b01 : 2'b00;
      end
      return e;
   endfunction

   // ---------------- monitor: one window per instruction, FETCH to FETCH ----
   int         m_cnt, m_rw, m_pcw, m_memw, m_req, m_adr, m_k, m_orphan;
   bit         m_in;
   logic [3:0] m_prev;
   logic [5:0] m_dsig, m_xsig;
   logic [2:0] m_imm;
   logic [1:0] m_rsrc;

   task automatic close_win(input bit is_trap);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("unexpected_instruction_end", 32'(state_dbg), 32'hFFFF_FFFF);
         return;
      end
      e = exp_q.pop_front();
      chk("trap_taken", 32'(is_trap), 32'(e.trap));
      chk("cycles", m_cnt, e.cyc);
      if (is_trap) chk("trap_out", 32'(trap), 1);
      if (!is_trap && !e.trap) begin
         chk("regwrite_count", m_rw, e.rw);
         chk("pcwrite_count", m_pcw, e.pcw);
         chk("store_done_count", m_memw, e.memw);
         chk("mem_req_cycles", m_req, e.req);
         chk("adrsrc_cycles", m_adr, e.adr);
         chk("decode_sel", 32'(m_dsig), 32'(e.dsig));
         chk("exec_sel", 32'(m_xsig), 32'(e.xsig));
         chk("immsrc", 32'(m_imm), 32'(e.imm));
         chk("wb_resultsrc", 32'(m_rsrc), 32'(e.rsrc));
         chk("memwrite_without_req", m_orphan, 0);
      end
   endtask

   initial begin : monitor
      m_in = 1'b0;
      m_prev = 4'd0;
      forever begin
         @(negedge clk);
         if (reset || !mon_en) begin
            m_in = 1'b0;
         end else if (m_in && state_dbg == 4'd14) begin
            close_win(1'b1);
            m_in = 1'b0;
         end else begin
            if (m_in && state_dbg == 4'd0 && m_prev != 4'd0) begin
               close_win(1'b0);
               m_in = 1'b0;
            end
            if (!m_in && state_dbg == 4'd0) begin
               m_in = 1'b1; m_cnt = 0; m_rw = 0; m_pcw = 0; m_memw = 0; m_req = 0;
               m_adr = 0; m_k = -1; m_orphan = 0;
               m_dsig = '0; m_xsig = '0; m_imm = '0; m_rsrc = '0;
            end
            if (m_in) begin
               m_cnt++;
               m_rw   += int'(RegWrite);
               m_pcw  += int'(PCWrite);
               m_memw += int'(MemWrite && mem_req && mem_ready);
               m_req  += int'(mem_req);
               m_adr  += int'(mem_req && AdrSrc);
               m_orphan += int'(MemWrite && !mem_req);
               if (RegWrite) m_rsrc = ResultSrc;
               if (IRWrite) begin
                  m_k = 0;
                  chk("fetch_sel", 32'({AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc}),
                      32'(9'b0_00_10_00_10));
               end else if (m_k >= 0) begin
                  m_k++;
                  if (m_k == 1) begin
                     m_dsig = {ALUSrcA, ALUSrcB, ALUOp};
                     m_imm  = ImmSrc;
                  end
                  if (m_k == 2) m_xsig = {ALUSrcA, ALUSrcB, ALUOp};
               end
            end
         end
         m_prev = state_dbg;
      end
   end

   // ---------------- stimulus ------------------------------------------------
   task automatic serve(input int n);
      mem_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget, input string name);
      int n = 0;
      while (state_dbg !== s && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, 32'(state_dbg), 32'(s));
   endtask

   task automatic wait_access();
      int n = 0;
      while (!(mem_req === 1'b1 && AdrSrc === 1'b1) && n < 6) begin
         @(posedge clk); #1;
         n++;
      end
      chk("data_access_seen", 32'(mem_req && AdrSrc), 1);
   endtask

   task automatic trap_hold();
      int bad = 0;
      for (int i = 0; i < 4; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         op = 7'b0110011;
         #1;
         if (trap !== 1'b1 || mem_req || PCWrite || IRWrite || RegWrite || MemWrite ||
             state_dbg !== 4'd14) bad++;
         @(posedge clk); #1;
      end
      chk("trap_sticky", bad, 0);
      mem_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("trap_cleared_by_reset", 32'({trap, state_dbg}), 0);
      reset = 1'b0;
   endtask

   task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input bit z,
                            input bit r, input int sf, input int sm);
      exp_t e = model(o, f, z, r, sf, sm);
      bit   mem = (cls(o) <= 1);
      exp_q.push_back(e);
      op = o; funct3 = f; Zero = z; ALUR31 = r; funct7b5 = 1'($urandom_range(0, 1));
      serve(sf);
      if (e.trap) begin
         if (mem && sf < TIMEOUT) begin
            wait_access();
            serve(sm);
         end
         wait_state(4'd14, 40, "reach_trap");
         trap_hold();
      end else begin
         if (mem) begin
            wait_access();
            serve(sm);
         end
         wait_state(4'd0, 10, "back_to_fetch");
      end
   endtask

   function automatic int rnd_stall();
      return ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 14)) : int'($urandom_range(0, 2));
   endfunction

   logic [6:0] legal [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

   initial begin
      logic [6:0] ill;
      reset = 1'b1; mem_ready = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
      Zero = 1'b0; ALUR31 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      mem_ready = 1'b1;
      #1;
      chk("reset_state", 32'(state_dbg), 0);
      chk("reset_trap", 32'(trap), 0);
      chk("reset_strobes", 32'({mem_req, PCWrite, IRWrite, RegWrite, MemWrite}), 0);
      mem_ready = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      reset  = 1'b0;

      // Directed: add, lw with 3 stalls, bne both ways, bgeu, watchdog boundaries
      run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);
      run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 3);
      run_instr(7'b1100011, 3'd1, 1'b1, 1'b0, 0, 0);
      run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0);
      run_instr(7'b1100011, 3'd7, 1'b0, 1'b0, 0, 0);
      run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, TIMEOUT - 1, TIMEOUT - 1);
      run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);
      run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, TIMEOUT, 0);
      run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 1, TIMEOUT);
      run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, TIMEOUT);

      for (int i = 0; i < 70; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            ill = 7'($urandom_range(0, 127));
            while (cls(ill) != 9) ill = 7'($urandom_range(0, 127));
            run_instr(ill, 3'($urandom), 1'($urandom), 1'($urandom), rnd_stall(), 0);
         end else begin
            run_instr(legal[$urandom_range(0, 8)], 3'($urandom), 1'($urandom),
                      1'($urandom), rnd_stall(), rnd_stall());
         end
      end
      run_instr(7'b0010111, 3'd0, 1'b0, 1'b0, 0, 0);

      @(negedge clk); #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      mon_en = 1'b0;

      // Reset asserted while a store is being accepted
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      op = 7'b0100011;
      serve(0);
      wait_state(4'd5, 6, "reach_memwrite");
      mem_ready = 1'b1;
      reset = 1'b1;
      #1;
      chk("reset_kills_store", 32'({MemWrite, mem_req}), 0);
      @(posedge clk); #1;
      chk("reset_next_fetch", 32'(state_dbg), 0);
      reset = 1'b0;
      mem_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: got running expected finished");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
